// File: rtl/clock_gate_scheduler_if.sv
// Signal bundle between the clock-gate scheduler and its environment:
// activity/wake inputs in, ICG enables and status out.
interface clock_gate_scheduler_if #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8
);
  logic [IDLE_W-1:0]      idle_thresh;
  logic [NUM_DOMAINS-1:0] busy;
  logic [NUM_DOMAINS-1:0] wake_req;
  logic                   force_on;
  logic [NUM_DOMAINS-1:0] gate_en;
  logic [NUM_DOMAINS-1:0] domain_ready;
  logic                   wake_busy;

  modport master (
    output idle_thresh, busy, wake_req, force_on,
    input  gate_en, domain_ready, wake_busy
  );

  modport slave (
    input  idle_thresh, busy, wake_req, force_on,
    output gate_en, domain_ready, wake_busy
  );
endinterface

// File: rtl/clock_gate_scheduler.sv
// Per-domain idle-driven clock gating with a single round-robin wake slot,
// so at most one clock tree ramps up at a time.
module clock_gate_scheduler #(
  parameter int NUM_DOMAINS = 4,
  parameter int IDLE_W      = 8,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  clock_gate_scheduler_if.slave io_bus
);
  localparam int PTR_W = $clog2(NUM_DOMAINS);

  localparam logic [1:0] ST_ON   = 2'd0;
  localparam logic [1:0] ST_OFF  = 2'd1;
  localparam logic [1:0] ST_WAKE = 2'd2;

  localparam logic [3:0]       WAKE_LAST = 4'(WAKE_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_DOMAINS - 1);

  logic [NUM_DOMAINS-1:0] w_wake_cond;
  logic [NUM_DOMAINS-1:0] w_req;
  logic [NUM_DOMAINS-1:0] w_in_wake;
  logic [NUM_DOMAINS-1:0] w_next_wake;
  logic [NUM_DOMAINS-1:0] w_grant;
  logic [NUM_DOMAINS-1:0] w_gate_en;
  logic [NUM_DOMAINS-1:0] w_ready;
  logic                   w_slot_free;
  logic                   w_grant_vld;
  logic [PTR_W-1:0]       w_grant_idx;
  logic [PTR_W-1:0]       r_rr_ptr;
  logic                   r_wake_busy;

  assign w_wake_cond = io_bus.busy | io_bus.wake_req | {NUM_DOMAINS{io_bus.force_on}};
  assign w_slot_free = ~|w_in_wake;

  // Round-robin search starting at r_rr_ptr; first OFF domain with a wake condition wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_DOMAINS) begin
        idx = idx - NUM_DOMAINS;
      end
      if (!w_grant_vld && w_req[idx]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = PTR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_slot_free && w_grant_vld) begin
      r_rr_ptr <= (w_grant_idx == PTR_LAST) ? '0 : w_grant_idx + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DOMAINS; gi++) begin : g_dom
      logic [1:0]        r_state;
      logic [1:0]        w_state_next;
      logic [IDLE_W-1:0] r_idle_cnt;
      logic [IDLE_W-1:0] w_idle_next;
      logic [3:0]        r_wake_cnt;
      logic [3:0]        w_wake_next;
      logic [IDLE_W:0]   w_idle_inc;
      logic              w_thresh_hit;
      logic              r_gate_en;
      logic              r_ready;

      assign w_req[gi]     = (r_state == ST_OFF) && w_wake_cond[gi];
      assign w_in_wake[gi] = (r_state == ST_WAKE);
      assign w_grant[gi]   = w_slot_free && w_grant_vld && (w_grant_idx == PTR_W'(gi));

      // One extra bit so the +1 never wraps before the threshold compare.
      assign w_idle_inc   = {1'b0, r_idle_cnt} + 1'b1;
      assign w_thresh_hit = (io_bus.idle_thresh != '0) &&
                            (w_idle_inc >= {1'b0, io_bus.idle_thresh});

      always_comb begin
        w_state_next = r_state;
        w_idle_next  = r_idle_cnt;
        w_wake_next  = r_wake_cnt;
        case (r_state)
          ST_ON: begin
            if (w_wake_cond[gi]) begin
              w_idle_next = '0;
            end else if (w_thresh_hit) begin
              w_state_next = ST_OFF;
              w_idle_next  = '0;
            end else if (r_idle_cnt != '1) begin
              w_idle_next = r_idle_cnt + 1'b1;
            end
          end
          ST_OFF: begin
            w_idle_next = '0;
            if (w_grant[gi]) begin
              w_state_next = ST_WAKE;
              w_wake_next  = '0;
            end
          end
          ST_WAKE: begin
            if (r_wake_cnt == WAKE_LAST) begin
              w_state_next = ST_ON;
              w_idle_next  = '0;
              w_wake_next  = '0;
            end else begin
              w_wake_next = r_wake_cnt + 1'b1;
            end
          end
          default: begin
            w_state_next = ST_ON;
            w_idle_next  = '0;
            w_wake_next  = '0;
          end
        endcase
      end

      assign w_next_wake[gi] = (w_state_next == ST_WAKE);

      // Outputs are registered copies of the next-state decode, so they align with r_state.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_state    <= ST_ON;
          r_idle_cnt <= '0;
          r_wake_cnt <= '0;
          r_gate_en  <= 1'b1;
          r_ready    <= 1'b1;
        end else begin
          r_state    <= w_state_next;
          r_idle_cnt <= w_idle_next;
          r_wake_cnt <= w_wake_next;
          r_gate_en  <= (w_state_next != ST_OFF);
          r_ready    <= (w_state_next == ST_ON);
        end
      end

      assign w_gate_en[gi] = r_gate_en;
      assign w_ready[gi]   = r_ready;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wake_busy <= 1'b0;
    end else begin
      r_wake_busy <= |w_next_wake;
    end
  end

  assign io_bus.gate_en      = w_gate_en;
  assign io_bus.domain_ready = w_ready;
  assign io_bus.wake_busy    = r_wake_busy;
endmodule
